// File: rtl/tsv_lane_sched_if.sv
// tsv_lane_sched_if: requester handshake and TSV lane bundle between requesters and the scheduler.
interface tsv_lane_sched_if #(
  parameter int NREQ = 4,
  parameter int DW = 8,
  parameter int LANES = 2
);
  localparam int SW = $clog2(NREQ);
  logic [NREQ-1:0] req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0] req_ready;
  logic [LANES-1:0] tsv_lane;
  logic tsv_sof;
  logic [SW-1:0] tsv_src;
  logic tsv_busy;
  modport master (output req_valid, req_data, input req_ready, tsv_lane, tsv_sof, tsv_src, tsv_busy);
  modport slave (input req_valid, req_data, output req_ready, tsv_lane, tsv_sof, tsv_src, tsv_busy);
endinterface

// File: rtl/tsv_lane_sched.sv
// tsv_lane_sched: round-robin serializer of requester words onto a narrow TSV lane bundle.
// Define TSV_PARITY_EN to append an XOR parity beat after every word.
module tsv_lane_sched #(
  parameter int NREQ = 4,
  parameter int DW = 8,
  parameter int LANES = 2,
  parameter int MAXBURST = 4
) (
  input logic clk1,
  input logic rst,
  tsv_lane_sched_if.slave bus
);
  localparam int BEATS = DW / LANES;
`ifdef TSV_PARITY_EN
  localparam int LAST = BEATS;
`else
  localparam int LAST = BEATS - 1;
`endif
  localparam int SW = $clog2(NREQ);
  localparam int BW = $clog2(BEATS + 2);
  localparam int CW = $clog2(MAXBURST + 1);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t state, state_n;
  logic [SW-1:0] rr_ptr, src, pick, sel;
  logic [DW-1:0] shreg, word;
  logic [BW-1:0] beat;
  logic [CW-1:0] burst;
  logic found, last, cont, load;
`ifdef TSV_PARITY_EN
  logic par;
`endif
  always_comb begin
    found = 1'b0;
    pick = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req_valid[(int'(rr_ptr) + i) % NREQ]) begin
        found = 1'b1;
        pick = SW'((int'(rr_ptr) + i) % NREQ);
      end
    end
  end
  always_comb begin
    last = state == SEND && beat == BW'(LAST);
    cont = last && bus.req_valid[src] && burst < CW'(MAXBURST);
    load = (state == IDLE && found) || cont;
    sel = state == IDLE ? pick : src;
    word = bus.req_data[sel*DW +: DW];
    state_n = state == IDLE ? (found ? SEND : IDLE) :
              state == SEND ? ((last && !cont) ? GAP : SEND) : IDLE;
  end
  // ready is masked during reset so no word is accepted while the block is held
  assign bus.req_ready = (load && !rst) ? (NREQ'(1) << sel) : '0;
`ifdef TSV_PARITY_EN
  assign bus.tsv_lane = state != SEND ? '0 : last ? LANES'(par) : shreg[LANES-1:0];
`else
  assign bus.tsv_lane = state == SEND ? shreg[LANES-1:0] : '0;
`endif
  assign bus.tsv_sof = state == SEND && beat == '0;
  assign bus.tsv_busy = state == SEND;
  assign bus.tsv_src = src;
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      src <= '0;
      shreg <= '0;
      beat <= '0;
      burst <= '0;
`ifdef TSV_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (load) begin
        shreg <= word;
        src <= sel;
        beat <= '0;
        burst <= state == IDLE ? CW'(1) : burst + CW'(1);
`ifdef TSV_PARITY_EN
        par <= ^word;
`endif
      end else if (state == SEND) begin
        shreg <= shreg >> LANES;
        beat <= beat + BW'(1);
        if (last) rr_ptr <= src == SW'(NREQ - 1) ? '0 : src + SW'(1);
      end
    end
  end
endmodule

// File: doc/tsv_lane_sched.md
# tsv_lane_sched

Round-robin scheduler that shares one narrow TSV lane bundle between several on-layer requesters. Each requester offers a DW-bit word with a valid/ready handshake. The scheduler grants one requester at a time and serializes its word onto LANES TSVs over DW/LANES beats, LSB chunk first, with a start-of-word strobe and source ID. It sits between the layer's counter/state-machine blocks and the TSV_CELL UP pins that feed the adjacent layer.

## Interface
- NREQ, 4, number of requesters (2..8)
- DW, 8, word width per requester
- LANES, 2, TSVs in the bundle; DW % LANES == 0 required; BEATS = DW/LANES
- MAXBURST, 4, max consecutive words from one requester before rotation (>=1)

- clk1  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  word offered by requester i
- req_data  in  NREQ*DW  word of requester i at bits [i*DW +: DW]
- req_ready  out  NREQ  one-hot accept pulse; transfer when valid & ready
- tsv_lane  out  LANES  serialized data beat to TSV UP pins
- tsv_sof  out  1  high on first beat of each word
- tsv_src  out  clog2(NREQ)  ID of requester whose word is on tsv_lane
- tsv_busy  out  1  high while in SEND (including parity beat)

## Operation
- States: IDLE, SEND, GAP.
- IDLE: if any req_valid, pick the first valid index at or after rr_ptr (wrapping). Assert req_ready[k] combinationally that cycle, latch req_data[k] into the shift register, set src=k, beat=0, burst=1, go SEND. If no valid, stay IDLE.
- SEND: drive tsv_lane = shreg[LANES-1:0] and tsv_sof = (beat==0); shift right by LANES per cycle; beat increments.
- Last beat, same-requester continuation: if req_valid[src] && burst < MAXBURST, assert req_ready[src], load the next word, set beat=0, burst+1, and stay in SEND with no bubble.
- Last beat, otherwise: go GAP and set rr_ptr = (src+1) mod NREQ.
- GAP: one turnaround cycle. tsv_lane=0, tsv_sof=0, tsv_busy=0. Then go IDLE.
- req_ready is never asserted for a requester whose req_valid is low, and never for more than one index at a time.
- A requester dropping req_valid mid-word does not abort the word already latched.
- The req_valid of non-granted requesters is ignored until IDLE.
- rr_ptr wraps from NREQ-1 to 0.

## Timing
- Reset values: state=IDLE, rr_ptr=0, shreg=0, tsv_lane=0, tsv_sof=0, tsv_src=0, tsv_busy=0, req_ready=0.
- Grant at cycle T (IDLE, valid seen): req_ready pulse in T. First beat (tsv_sof=1) in T+1. Last beat in T+BEATS.
- Burst: back-to-back words every BEATS cycles, no idle beat.
- Between grants: GAP at T+BEATS+1, IDLE at T+BEATS+2. The earliest next grant is T+BEATS+2, so its first beat is at T+BEATS+3.
- tsv_src is valid whenever tsv_busy=1. Outside SEND it holds its last value.
- Reset asserted mid-word: all outputs go to reset values immediately (asynchronous). The partial word is discarded and no req_ready is issued until reset deasserts.

## Configuration
- TSV_PARITY_EN defined: one extra beat follows the last data beat of every word.
  - On the parity beat, tsv_lane[0] = XOR of all DW bits of the word and the other lanes are 0; tsv_sof=0, tsv_busy=1.
  - Words take BEATS+1 cycles. The continuation decision and req_ready pulse move to the parity beat.
- TSV_PARITY_EN undefined: no parity beat; timing as above.

## Test plan
- Reset then idle: rst pulse, no valids -> all outputs 0, tsv_busy stays 0 for 20 cycles.
- Single word: req_valid[2]=1 with data 0xB4 at T, dropped after ready -> ready[2] at T. tsv_lane = 0,1,3,2 over T+1..T+4 with sof only at T+1. tsv_src=2. GAP at T+5.
- Round-robin fairness: all four valid continuously, MAXBURST=1 -> grant order 0,1,2,3,0. Grants are spaced BEATS+2 cycles apart.
- Burst cap: only req 1 valid continuously, MAXBURST=4 -> 4 words back-to-back (16 busy cycles). Then 1 GAP cycle, then a new grant to 1 with burst restarting.
- Reset mid-word: assert rst on the 2nd beat -> outputs 0 in the same cycle. After release, rr_ptr=0 and requester 0 is granted first if valid.
- Parity (TSV_PARITY_EN): word 0x07 -> beats 3,1,0,0, then parity beat tsv_lane=2'b01. tsv_busy is high for 5 cycles.
